// File: rtl/add_mult_pipe.sv
// add_mult_pipe
//   Accepts NUM_PAIRS operand pairs, forms the sum of each pair, then
//   multiplies the pair sums together one per cycle (ADD, then MUL x
//   NUM_PAIRS-1) and presents the product with a valid/ready handshake.
//   The result appears NUM_PAIRS clock edges after the accepting edge.
//
//   Build option: define ADD_MULT_SIGNED_EN to treat operands, sums and
//   the product as two's complement; otherwise everything is unsigned.
//   Cycle timing is identical in both builds.
//
// Ports
//   sys_clk    in   clock, all state changes on the rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   in_valid   in   operand set offered
//   in_ready   out  block can take an operand set this cycle
//   a_bus      in   first operand of each pair, pair i at [i*DATA_W +: DATA_W]
//   b_bus      in   second operand of each pair, same packing
//   out_valid  out  product on p is valid
//   out_ready  in   downstream takes the product
//   p          out  product of all pair sums, NUM_PAIRS*(DATA_W+1) bits
//   busy       out  high whenever the FSM is not idle
module add_mult_pipe #(
    parameter int DATA_W    = 8,
    parameter int NUM_PAIRS = 3
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_PAIRS*DATA_W-1:0]       a_bus,
    input  logic [NUM_PAIRS*DATA_W-1:0]       b_bus,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_PAIRS*(DATA_W+1)-1:0]   p,
    output logic                              busy
);

    localparam int SUM_W = DATA_W + 1;
    localparam int P_W   = NUM_PAIRS * SUM_W;
    localparam int IDX_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                        state;
    logic [NUM_PAIRS*DATA_W-1:0]   a_reg;
    logic [NUM_PAIRS*DATA_W-1:0]   b_reg;
    logic [P_W-1:0]                acc;
    logic [IDX_W-1:0]              idx;

    logic [SUM_W-1:0]              sums [NUM_PAIRS];
    logic [SUM_W-1:0]              sum_sel;
    logic [P_W-1:0]                prod_next;
    logic                          accept;

`ifdef ADD_MULT_SIGNED_EN
    function automatic logic [SUM_W-1:0] pair_sum(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic signed [SUM_W-1:0] sa;
        logic signed [SUM_W-1:0] sb;
        sa = {a[DATA_W-1], a};
        sb = {b[DATA_W-1], b};
        return sa + sb;
    endfunction

    function automatic logic [P_W-1:0] widen(input logic [SUM_W-1:0] s);
        logic signed [P_W-1:0] w;
        w = {{(P_W-SUM_W){s[SUM_W-1]}}, s};
        return w;
    endfunction

    function automatic logic [P_W-1:0] mul_step(input logic [P_W-1:0]   a,
                                                input logic [SUM_W-1:0] s);
        logic signed [P_W-1:0] x;
        logic signed [P_W-1:0] y;
        x = a;
        y = widen(s);
        return x * y;
    endfunction
`else
    function automatic logic [SUM_W-1:0] pair_sum(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [P_W-1:0] widen(input logic [SUM_W-1:0] s);
        return {{(P_W-SUM_W){1'b0}}, s};
    endfunction

    function automatic logic [P_W-1:0] mul_step(input logic [P_W-1:0]   a,
                                                input logic [SUM_W-1:0] s);
        logic [P_W-1:0] y;
        y = widen(s);
        return a * y;
    endfunction
`endif

    // Pair sums are formed from the captured operands, so input activity
    // after acceptance cannot reach the computation.
    for (genvar gi = 0; gi < NUM_PAIRS; gi++) begin : g_sum
        assign sums[gi] = pair_sum(a_reg[gi*DATA_W +: DATA_W],
                                   b_reg[gi*DATA_W +: DATA_W]);
    end

    always_comb begin
        sum_sel = '0;
        for (int i = 0; i < NUM_PAIRS; i++) begin
            if (idx == IDX_W'(i)) begin
                sum_sel = sums[i];
            end
        end
    end

    assign prod_next = mul_step(acc, sum_sel);

    // DONE can hand off and accept in the same edge when downstream is ready.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            idx       <= '0;
            p         <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                a_reg <= a_bus;
                b_reg <= b_bus;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= ADD;
                    end
                end
                ADD: begin
                    acc   <= widen(sums[0]);
                    idx   <= IDX_W'(1);
                    state <= MUL;
                end
                MUL: begin
                    acc <= prod_next;
                    idx <= idx + IDX_W'(1);
                    if (idx == IDX_W'(NUM_PAIRS-1)) begin
                        p         <= prod_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // p keeps the last product after hand-off until the next DONE.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= in_valid ? ADD : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_mult_pipe.sv
// tb_add_mult_pipe
//   Bench for add_mult_pipe: a default instance (DATA_W=8, NUM_PAIRS=3) and
//   a small instance (DATA_W=4, NUM_PAIRS=2). Expected products come from an
//   arithmetic model that extracts each operand, sums pairs and multiplies.
module tb_add_mult_pipe;

    localparam int DW  = 8;
    localparam int NP  = 3;
    localparam int PW  = NP * (DW + 1);
    localparam int DW2 = 4;
    localparam int NP2 = 2;
    localparam int PW2 = NP2 * (DW2 + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, out_valid, out_ready, busy;
    logic [NP*DW-1:0]  a_bus, b_bus;
    logic [PW-1:0]     p;

    logic              in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [NP2*DW2-1:0] a2, b2;
    logic [PW2-1:0]    p2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    add_mult_pipe #(.DATA_W(DW), .NUM_PAIRS(NP)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_bus(a_bus), .b_bus(b_bus),
        .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .busy(busy)
    );

    add_mult_pipe #(.DATA_W(DW2), .NUM_PAIRS(NP2)) dut2 (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .a_bus(a2), .b_bus(b2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .p(p2), .busy(busy2)
    );

    function automatic longint model(input int np, input int dw,
                                     input logic [63:0] a, input logic [63:0] b);
        longint prod, x, y, m;
        prod = 1;
        m = (longint'(1) << dw) - 1;
        for (int i = 0; i < np; i++) begin
            x = longint'(a >> (i*dw)) & m;
            y = longint'(b >> (i*dw)) & m;
`ifdef ADD_MULT_SIGNED_EN
            if (x >= (longint'(1) << (dw-1))) x = x - (longint'(1) << dw);
            if (y >= (longint'(1) << (dw-1))) y = y - (longint'(1) << dw);
`endif
            prod = prod * (x + y);
        end
        return prod & ((longint'(1) << (np*(dw+1))) - 1);
    endfunction

    // Offer one set on the next edge; assumes the DUT is able to take it.
    task automatic send(input logic [NP*DW-1:0] a, input logic [NP*DW-1:0] b);
        in_valid = 1'b1;
        a_bus    = a;
        b_bus    = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded so a dead DUT cannot hang the run.
    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (p !== '0) begin errors++; $display("FAIL reset_p got=%0d want=0", p); end
        checks++; if (out_valid2 !== 1'b0 || p2 !== '0) begin errors++; $display("FAIL reset_dut2 got=%b/%0d want=0/0", out_valid2, p2); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got=%b want=1", in_ready); end
        send({8'd5, 8'd3, 8'd1}, {8'd6, 8'd4, 8'd2});
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b want=1", busy); end
        wait_out(lat);
        checks++; if (lat != NP) begin errors++; $display("FAIL basic_latency got=%0d want=%0d", lat, NP); end
        checks++; if (p !== 27'd231) begin errors++; $display("FAIL basic_p got=%0d want=231", p); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got=%b/%b want=0/0", out_valid, busy); end
        checks++; if (p !== 27'd231) begin errors++; $display("FAIL basic_p_hold got=%0d want=231", p); end
    endtask

    task automatic test_all_ones;
        int lat;
        logic [PW-1:0] want;
`ifdef ADD_MULT_SIGNED_EN
        want = 27'h7FFFFF8;
`else
        want = 27'd132651000;
`endif
        send('1, '1);
        wait_out(lat);
        checks++; if (lat != NP || p !== want) begin errors++; $display("FAIL all_ones got=%0d lat=%0d want=%0d lat=%0d", p, lat, want, NP); end
        @(posedge clk); #1;
    endtask

    task automatic test_signed_mix;
        int lat;
        logic [PW-1:0] want;
`ifdef ADD_MULT_SIGNED_EN
        want = 27'h7FFFFF4;
`else
        want = 27'd3060;
`endif
        send({8'h02, 8'h01, 8'hFF}, {8'h01, 8'h01, 8'hFF});
        wait_out(lat);
        checks++; if (lat != NP || p !== want) begin errors++; $display("FAIL mix got=%0h lat=%0d want=%0h lat=%0d", p, lat, want, NP); end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        int lat;
        logic [NP*DW-1:0] a, b;
        logic [PW-1:0] want;
        for (int k = 0; k < 12; k++) begin
            a = (NP*DW)'($urandom);
            b = (NP*DW)'($urandom);
            want = PW'(model(NP, DW, 64'(a), 64'(b)));
            send(a, b);
            wait_out(lat);
            checks++; if (lat != NP || p !== want) begin errors++; $display("FAIL random%0d got=%0h lat=%0d want=%0h lat=%0d", k, p, lat, want, NP); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [NP*DW-1:0] a, b, c;
        logic [PW-1:0] want_a, want_b;
        a = 24'h0A1B2C; b = 24'h030405; c = 24'h7F7F7F;
        want_a = PW'(model(NP, DW, 64'(a), 64'(b)));
        want_b = PW'(model(NP, DW, 64'(c), 64'(a)));
        out_ready = 1'b0;
        send(a, b);
        // Junk offered through ADD, MUL and DONE must be ignored.
        in_valid = 1'b1; a_bus = 24'hFFFFFF; b_bus = 24'h123456;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_busy got=%b want=0", in_ready); end
        wait_out(lat);
        checks++; if (lat != NP || p !== want_a) begin errors++; $display("FAIL bp_first got=%0h lat=%0d want=%0h lat=%0d", p, lat, want_a, NP); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || p !== want_a || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got=%b/%0h/%b want=1/%0h/0", k, out_valid, p, in_ready, want_a);
            end
        end
        a_bus = c; b_bus = a;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_done got=%b want=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_handoff got=%b/%b want=0/1", out_valid, busy); end
        wait_out(lat);
        checks++; if (lat != NP || p !== want_b) begin errors++; $display("FAIL bp_second got=%0h lat=%0d want=%0h lat=%0d", p, lat, want_b, NP); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [PW-1:0] want;
        send(24'h112233, 24'h010203);
        @(posedge clk); #1;   // ADD done, now in MUL
        @(posedge clk); #1;   // still in MUL
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || p !== '0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid got=%b/%b/%0h/%b want=0/0/0/1", out_valid, busy, p, in_ready);
        end
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_stale%0d got=%b/%b want=0/0", k, out_valid, busy); end
        end
        want = PW'(model(NP, DW, 64'(24'h050607), 64'(24'h080910)));
        send(24'h050607, 24'h080910);
        wait_out(lat);
        checks++; if (lat != NP || p !== want) begin errors++; $display("FAIL rst_next got=%0h lat=%0d want=%0h lat=%0d", p, lat, want, NP); end
        @(posedge clk); #1;
    endtask

    task automatic test_two_pairs;
        int lat;
        logic [PW2-1:0] want;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin a2 = 8'hFF; b2 = 8'hFF; end
            else begin a2 = 8'($urandom); b2 = 8'($urandom); end
            want = PW2'(model(NP2, DW2, 64'(a2), 64'(b2)));
            if (k == 0) begin
`ifdef ADD_MULT_SIGNED_EN
                want = 10'd4;
`else
                want = 10'd900;
`endif
            end
            in_valid2 = 1'b1;
            @(posedge clk); #1;
            in_valid2 = 1'b0;
            lat = 0;
            while (out_valid2 !== 1'b1 && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++; if (lat != NP2 || p2 !== want) begin errors++; $display("FAIL pairs2_%0d got=%0d lat=%0d want=%0d lat=%0d", k, p2, lat, want, NP2); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b1; a_bus = '0; b_bus = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0;
        test_reset;
        test_basic;
        test_all_ones;
        test_signed_mix;
        test_random;
        test_back_to_back;
        test_reset_mid;
        test_two_pairs;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/add_mult_pipe.md
ADD_MULT_PIPE -- requirements
Module: add_mult_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width in bits (legal 2..16).
REQ-002 SHALL have parameter NUM_PAIRS, default 3, number of operand pairs summed then multiplied (legal 2..4).
REQ-003 SHALL derive localparam SUM_W = DATA_W+1 and P_W = NUM_PAIRS*SUM_W (default 27).
REQ-004 SHALL have port sys_clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port sys_rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid, input, 1, operand set valid.
REQ-007 SHALL have port in_ready, output, 1, block can accept an operand set.
REQ-008 SHALL have port a_bus, input, NUM_PAIRS*DATA_W, first operand of each pair; pair i = bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port b_bus, input, NUM_PAIRS*DATA_W, second operand of each pair, same packing.
REQ-010 SHALL have port out_valid, output, 1, product valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts product.
REQ-012 SHALL have port p, output, P_W, product of all pair sums.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> ADD -> MUL -> DONE -> IDLE.
REQ-015 Acceptance SHALL occur on an edge where in_valid && in_ready; a_bus/b_bus captured into internal registers on that edge; state -> ADD.
REQ-016 in_ready SHALL be 1 in IDLE, 1 in DONE while out_ready is 1, otherwise 0.
REQ-017 ADD (one cycle): sum[i] = a[i] + b[i] at SUM_W bits, no truncation; acc <= sum[0]; idx <= 1; state -> MUL.
REQ-018 MUL: each cycle acc <= acc * sum[idx] at P_W bits, idx++; after the multiply with idx = NUM_PAIRS-1, state -> DONE; exactly NUM_PAIRS-1 MUL cycles.
REQ-019 out_valid SHALL rise exactly NUM_PAIRS edges after the acceptance edge (3 at default) and p SHALL equal acc while out_valid is 1.
REQ-020 DONE: p and out_valid SHALL hold stable while out_ready is 0 (no overwrite, no drop).
REQ-021 DONE with out_ready = 1: output consumed; if in_valid = 1 on the same edge, the new set SHALL be accepted (state -> ADD, out_valid -> 0); else state -> IDLE, out_valid -> 0.
REQ-022 in_valid during ADD/MUL SHALL be ignored (in_ready = 0) and SHALL NOT disturb the computation.
REQ-023 p SHALL hold last product after consumption until next DONE; no combinational path from inputs to p.

Reset
REQ-024 sys_rst_n low SHALL immediately force state IDLE, in_ready 1, out_valid 0, busy 0, p 0, acc 0, idx 0, captured operands 0.
REQ-025 Reset mid-ADD/MUL/DONE SHALL abort the operation; no out_valid pulse for the aborted set after release.
REQ-026 First acceptance SHALL be possible on the first rising edge after sys_rst_n deasserts.

Configuration
REQ-027 Macro ADD_MULT_SIGNED_EN defined: operands two's complement, sums sign-extended to SUM_W, product signed P_W two's complement.
REQ-028 ADD_MULT_SIGNED_EN undefined: operands, sums and product unsigned, zero-extended; timing identical in both builds.

Verification
REQ-029 Defaults, unsigned, pairs (1,2),(3,4),(5,6), out_ready=1 -> p = 231 with out_valid high 3 cycles after acceptance, for 1 cycle.
REQ-030 Defaults, unsigned, all operands 255 -> p = 132651000 (fits 27 bits, no truncation).
REQ-031 Defaults, ADD_MULT_SIGNED_EN, pairs (FF,FF),(01,01),(02,01) -> p = 27'h7FFFFF4 (-12); same stimulus unsigned build -> p = 3060.
REQ-032 out_ready held 0 for 5 cycles in DONE, in_valid pulsed during ADD/MUL/DONE -> p/out_valid stable, no acceptance; then out_ready=1 with in_valid=1 -> back-to-back acceptance on same edge, next result correct.
REQ-033 sys_rst_n pulsed low during MUL -> outputs to reset values immediately, no stale out_valid after release; next set computes correctly.
REQ-034 NUM_PAIRS=2, DATA_W=4, pairs (15,15),(15,15) -> p = 900 (P_W = 10), out_valid 2 cycles after acceptance.
